// File: rtl/i2c_eeprom_access_arbiter_if.sv
// Bus bundle between the EEPROM access arbiter, its two requesters and the
// I2C EEPROM controller.
//   slave  : arbiter view (requests/status in, grants/controller drive out)
//   master : environment view (requesters + controller), directions mirrored
// Requester side : i_clk_rate, i_req_x, i_wr_x, i_addr_x, i_wdata_x,
//                  o_gnt_x, o_done_x, o_err, o_rdata, o_busy
// Controller side: o_ctrl, o_dev_addr, o_reg_addr, o_w_data,
//                  i_status, i_rd_data0..3
interface i2c_eeprom_access_arbiter_if;
  logic [2:0]  i_clk_rate;
  logic        i_req_a;
  logic        i_req_b;
  logic        i_wr_a;
  logic        i_wr_b;
  logic [15:0] i_addr_a;
  logic [15:0] i_addr_b;
  logic [31:0] i_wdata_a;
  logic [31:0] i_wdata_b;
  logic        o_gnt_a;
  logic        o_gnt_b;
  logic        o_done_a;
  logic        o_done_b;
  logic        o_err;
  logic [31:0] o_rdata;
  logic        o_busy;
  logic [31:0] o_ctrl;
  logic [6:0]  o_dev_addr;
  logic [15:0] o_reg_addr;
  logic [31:0] o_w_data;
  logic [31:0] i_status;
  logic [7:0]  i_rd_data0;
  logic [7:0]  i_rd_data1;
  logic [7:0]  i_rd_data2;
  logic [7:0]  i_rd_data3;

  modport slave (
    input  i_clk_rate, i_req_a, i_req_b, i_wr_a, i_wr_b, i_addr_a, i_addr_b,
           i_wdata_a, i_wdata_b, i_status, i_rd_data0, i_rd_data1, i_rd_data2, i_rd_data3,
    output o_gnt_a, o_gnt_b, o_done_a, o_done_b, o_err, o_rdata, o_busy, o_ctrl,
           o_dev_addr, o_reg_addr, o_w_data
  );

  modport master (
    output i_clk_rate, i_req_a, i_req_b, i_wr_a, i_wr_b, i_addr_a, i_addr_b,
           i_wdata_a, i_wdata_b, i_status, i_rd_data0, i_rd_data1, i_rd_data2, i_rd_data3,
    input  o_gnt_a, o_gnt_b, o_done_a, o_done_b, o_err, o_rdata, o_busy, o_ctrl,
           o_dev_addr, o_reg_addr, o_w_data
  );
endinterface

// File: rtl/i2c_eeprom_access_arbiter.sv
// Round-robin sequencer in front of the I2C EEPROM controller. Grants one of
// two 32-bit read/write requesters, pulses the controller enable, waits for
// finish, holds finish-clear until the controller drops finish, then waits the
// EEPROM write-cycle time after writes before reporting done.
// Ports:
//   i_clk : system clock
//   i_rst : asynchronous active-high reset (controller shares it)
//   bus   : requester handshakes and controller control/status (slave view)
module i2c_eeprom_access_arbiter #(
  parameter logic [6:0]  DEV_ADDR       = 7'h50,
  parameter int unsigned TWR_CYCLES     = 500000,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input logic                          i_clk,
  input logic                          i_rst,
  i2c_eeprom_access_arbiter_if.slave   bus
);

  localparam logic [31:0] TwrLast = 32'(TWR_CYCLES - 1);
  localparam logic [31:0] TmoLast = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StLaunch, StWaitDone, StClear, StTwr, StResp} state_e;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;

  // Two-flop synchronisers for the slow-domain status bits and read bytes.
  logic [1:0]  fin_sync_q;
  logic [1:0]  smen_sync_q;
  logic        fin_hist_q;
  logic [31:0] rd_s1_q, rd_s2_q;

  logic        owner_b_q;   // 1 = current transaction belongs to B
  logic        last_b_q;    // 1 = B served last, so A wins a tie
  logic        rd_q;
  logic [2:0]  rate_q;
  logic [15:0] reg_addr_q;
  logic [31:0] w_data_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic fin_s, smen_s, fin_stable;
  logic any_req, pick_b, in_wait, tmo_exp, twr_done, active;

  assign fin_s      = fin_sync_q[1];
  assign smen_s     = smen_sync_q[1];
  // Finish must be seen on two consecutive synchronised samples before bytes are used.
  assign fin_stable = fin_s & fin_hist_q;

  assign any_req  = bus.i_req_a | bus.i_req_b;
  assign pick_b   = bus.i_req_b & (~bus.i_req_a | ~last_b_q);
  assign in_wait  = (state_q == StLaunch) || (state_q == StWaitDone) || (state_q == StClear);
  assign tmo_exp  = in_wait && (cnt_q == TmoLast);
  assign twr_done = (cnt_q == TwrLast);
  assign active   = (state_q == StLaunch) || (state_q == StWaitDone) ||
                    (state_q == StClear) || (state_q == StTwr);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      fin_sync_q  <= '0;
      smen_sync_q <= '0;
      fin_hist_q  <= 1'b0;
      rd_s1_q     <= '0;
      rd_s2_q     <= '0;
    end else begin
      fin_sync_q  <= {fin_sync_q[0], bus.i_status[1]};
      smen_sync_q <= {smen_sync_q[0], bus.i_status[10]};
      fin_hist_q  <= fin_sync_q[1];
      rd_s1_q     <= {bus.i_rd_data0, bus.i_rd_data1, bus.i_rd_data2, bus.i_rd_data3};
      rd_s2_q     <= rd_s1_q;
    end
  end

  // State register; the shared wait counter restarts on every state change.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (any_req) state_d = StLaunch;
      StLaunch: begin
        if (tmo_exp)     state_d = StResp;
        else if (smen_s) state_d = StWaitDone;
      end
      StWaitDone: begin
        if (tmo_exp)         state_d = StResp;
        else if (fin_stable) state_d = StClear;
      end
      StClear: begin
        if (tmo_exp)     state_d = StResp;
        else if (!fin_s) state_d = rd_q ? StResp : StTwr;
      end
      StTwr:      if (twr_done) state_d = StResp;
      StResp:     state_d = StIdle;
      default:    state_d = StIdle;
    endcase
    cnt_d = ((state_d != state_q) || (state_q == StIdle)) ? '0 : cnt_q + 32'd1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      owner_b_q  <= 1'b0;
      last_b_q   <= 1'b1;
      rd_q       <= 1'b0;
      rate_q     <= '0;
      reg_addr_q <= '0;
      w_data_q   <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      if (state_q == StIdle && any_req) begin
        owner_b_q  <= pick_b;
        rd_q       <= pick_b ? ~bus.i_wr_b : ~bus.i_wr_a;
        reg_addr_q <= pick_b ? bus.i_addr_b : bus.i_addr_a;
        w_data_q   <= pick_b ? bus.i_wdata_b : bus.i_wdata_a;
        rate_q     <= bus.i_clk_rate;
        err_q      <= 1'b0;
      end
      if (tmo_exp) err_q <= 1'b1;
      if (state_q == StWaitDone && fin_stable && !tmo_exp && rd_q) rdata_q <= rd_s2_q;
      if (state_q == StResp) last_b_q <= owner_b_q;
    end
  end

  always_comb begin
    bus.o_ctrl      = '0;
    // Rate follows the input while idle and is frozen at grant.
    bus.o_ctrl[6:4] = (state_q == StIdle) ? bus.i_clk_rate : rate_q;
    bus.o_ctrl[3:1] = {2'b00, rd_q};
    bus.o_ctrl[0]   = (state_q == StLaunch);
    // Clear is a level hold for the whole CLEAR state, not a pulse.
    bus.o_ctrl[7]   = (state_q == StClear);
    bus.o_gnt_a     = active & ~owner_b_q;
    bus.o_gnt_b     = active & owner_b_q;
    bus.o_done_a    = (state_q == StResp) & ~owner_b_q;
    bus.o_done_b    = (state_q == StResp) & owner_b_q;
    bus.o_err       = (state_q == StResp) & err_q;
    bus.o_busy      = (state_q != StIdle);
    bus.o_rdata     = rdata_q;
    bus.o_dev_addr  = DEV_ADDR;
    bus.o_reg_addr  = reg_addr_q;
    bus.o_w_data    = w_data_q;
  end

endmodule

// File: tb/tb_i2c_eeprom_access_arbiter.sv
// Directed bench for i2c_eeprom_access_arbiter with a behavioural controller
// model and a scoreboard of expected completions.
module tb_i2c_eeprom_access_arbiter;
  localparam int unsigned TWR = 20;
  localparam int unsigned TMO = 200;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  i2c_eeprom_access_arbiter_if bus ();

  i2c_eeprom_access_arbiter #(
    .DEV_ADDR      (7'h50),
    .TWR_CYCLES    (TWR),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  typedef struct packed {
    logic        who;   // 0 = A, 1 = B
    logic        err;
    logic        chk;   // compare o_rdata
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // ---------------- controller model ----------------
  logic        nack_mode = 1'b0;
  logic [1:0]  m_st;
  logic [3:0]  m_cnt;
  logic        m_finish, m_smen, m_en_q;
  logic [55:0] m_bytes;
  logic [7:0]  mem [256];
  logic [7:0]  ma;
  assign ma = bus.o_reg_addr[7:0];
  assign bus.i_status = {21'd0, m_smen, 6'd0, m_st, m_finish, 1'b0};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_st <= 2'd0; m_cnt <= '0; m_finish <= 1'b0; m_smen <= 1'b0; m_en_q <= 1'b0;
      bus.i_rd_data0 <= '0; bus.i_rd_data1 <= '0; bus.i_rd_data2 <= '0; bus.i_rd_data3 <= '0;
    end else begin
      m_en_q <= bus.o_ctrl[0];
      case (m_st)
        2'd0: if (bus.o_ctrl[0] && !m_en_q) begin
          m_smen  <= 1'b1;
          m_cnt   <= '0;
          m_bytes <= {bus.o_dev_addr, 1'b0, bus.o_reg_addr, bus.o_w_data};
          if (nack_mode) m_st <= 2'd3;
          else begin
            m_st <= 2'd1;
            if (bus.o_ctrl[3:1] == 3'd0) begin
              mem[ma]        <= bus.o_w_data[31:24];
              mem[ma + 8'd1] <= bus.o_w_data[23:16];
              mem[ma + 8'd2] <= bus.o_w_data[15:8];
              mem[ma + 8'd3] <= bus.o_w_data[7:0];
            end
          end
        end
        2'd1: begin
          m_cnt <= m_cnt + 4'd1;
          if (m_cnt == 4'd10) begin
            m_smen <= 1'b0; m_finish <= 1'b1; m_st <= 2'd2;
            bus.i_rd_data0 <= mem[ma];        bus.i_rd_data1 <= mem[ma + 8'd1];
            bus.i_rd_data2 <= mem[ma + 8'd2]; bus.i_rd_data3 <= mem[ma + 8'd3];
          end
        end
        2'd2: if (bus.o_ctrl[7]) begin m_finish <= 1'b0; m_st <= 2'd0; end
        default: begin
          m_cnt <= m_cnt + 4'd1;
          if (m_cnt == 4'd5) begin m_smen <= 1'b0; m_st <= 2'd0; end
        end
      endcase
    end
  end

  // ---------------- monitors ----------------
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   t_c0_fall = 0, t_c7_fall = 0, t_gntb_rise = 0, t_done = 0;
  int   en_pulses = 0, c7_falls = 0, clr_early = 0, overlap = 0;
  logic c0_prev = 1'b0, c7_prev = 1'b0, gntb_prev = 1'b0;
  logic [2:0] op_seen = '0;
  always @(negedge clk) begin
    c0_prev   <= bus.o_ctrl[0];
    c7_prev   <= bus.o_ctrl[7];
    gntb_prev <= bus.o_gnt_b;
    if (bus.o_ctrl[0] && !c0_prev) en_pulses <= en_pulses + 1;
    if (!bus.o_ctrl[0] && c0_prev) t_c0_fall <= cyc;
    if (bus.o_ctrl[0]) op_seen <= bus.o_ctrl[3:1];
    if (!bus.o_ctrl[7] && c7_prev) begin
      t_c7_fall <= cyc;
      c7_falls  <= c7_falls + 1;
      if (m_finish) clr_early <= clr_early + 1;
    end
    if (bus.o_gnt_b && !gntb_prev) t_gntb_rise <= cyc;
    if (bus.o_gnt_a && bus.o_gnt_b) overlap <= overlap + 1;
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic who, input logic err, input logic chk,
                          input logic [31:0] rdata);
    exp_t e;
    e.who = who; e.err = err; e.chk = chk; e.rdata = rdata;
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input string tag);
    exp_t e;
    int   i = 0;
    @(negedge clk);
    while (!(bus.o_done_a || bus.o_done_b) && i < 1000) begin
      @(negedge clk);
      i++;
    end
    if (!(bus.o_done_a || bus.o_done_b)) begin
      check({tag, "_done_timeout"}, 64'd0, 64'd1);
      return;
    end
    t_done = cyc;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_underflow"}, 64'(exp_q.size()), 64'd1);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_who"}, {bus.o_done_a, bus.o_done_b}, e.who ? 2'b01 : 2'b10);
    check({tag, "_err"}, bus.o_err, e.err);
    if (e.chk) check({tag, "_rdata"}, bus.o_rdata, e.rdata);
  endtask

  task automatic wait_c7_fall(input string tag);
    int start = c7_falls;
    int i = 0;
    while (c7_falls == start && i < 1000) begin
      @(negedge clk);
      i++;
    end
    if (c7_falls == start) check({tag, "_clear_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"},   {bus.o_gnt_a, bus.o_gnt_b}, 2'b00);
    check({tag, "_done"},  {bus.o_done_a, bus.o_done_b}, 2'b00);
    check({tag, "_err"},   bus.o_err, 1'b0);
    check({tag, "_busy"},  bus.o_busy, 1'b0);
    check({tag, "_rdata"}, bus.o_rdata, 32'd0);
    check({tag, "_ctrl"},  bus.o_ctrl, 32'(bus.i_clk_rate) << 4);
    check({tag, "_dev"},   bus.o_dev_addr, 7'h50);
    check({tag, "_raddr"}, bus.o_reg_addr, 16'd0);
    check({tag, "_wdata"}, bus.o_w_data, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  int en0;
  initial begin
    bus.i_clk_rate = 3'd5;
    bus.i_req_a = 0; bus.i_req_b = 0; bus.i_wr_a = 0; bus.i_wr_b = 0;
    bus.i_addr_a = '0; bus.i_addr_b = '0; bus.i_wdata_a = '0; bus.i_wdata_b = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: A write, rate frozen at grant, tWR measured from clear release
    en0 = en_pulses;
    bus.i_req_a = 1; bus.i_wr_a = 1; bus.i_addr_a = 16'h0010; bus.i_wdata_a = 32'hDEADBEEF;
    push_exp(1'b0, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 20 && !bus.o_gnt_a; i++) @(negedge clk);
    check("t1_gnt", bus.o_gnt_a, 1'b1);
    bus.i_clk_rate = 3'd2;
    @(negedge clk);
    check("t1_rate_frozen", bus.o_ctrl[6:4], 3'd5);
    check("t1_opmode", bus.o_ctrl[3:1], 3'd0);
    bus.i_clk_rate = 3'd5;
    wait_done("t1");
    bus.i_req_a = 0;
    check("t1_twr_cycles", 64'(t_done - t_c7_fall), 64'(TWR));
    check("t1_en_pulses", 64'(en_pulses - en0), 64'd1);
    check("t1_bytes", m_bytes, 56'hA0_0010_DEADBEEF);

    // 2: B read of the same location
    @(negedge clk);
    bus.i_req_b = 1; bus.i_wr_b = 0; bus.i_addr_b = 16'h0010;
    push_exp(1'b1, 1'b0, 1'b1, 32'hDEADBEEF);
    wait_done("t2");
    bus.i_req_b = 0;
    check("t2_opmode", op_seen, 3'd1);
    check("t2_clear_held", 64'(clr_early), 64'd0);

    // 3: simultaneous requests twice -> A, B, A, B
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      bus.i_req_a = 1; bus.i_wr_a = 0; bus.i_addr_a = 16'h0010;
      bus.i_req_b = 1; bus.i_wr_b = 0; bus.i_addr_b = 16'h0010;
      push_exp(1'b0, 1'b0, 1'b1, 32'hDEADBEEF);
      push_exp(1'b1, 1'b0, 1'b1, 32'hDEADBEEF);
      wait_done("t3a");
      bus.i_req_a = 0;
      wait_done("t3b");
      bus.i_req_b = 0;
    end
    check("t3_overlap", 64'(overlap), 64'd0);

    // 4: NACK -> timeout with error, rdata kept; then a normal write
    nack_mode = 1'b1;
    @(negedge clk);
    bus.i_req_a = 1; bus.i_wr_a = 1; bus.i_addr_a = 16'h0050; bus.i_wdata_a = 32'h11223344;
    push_exp(1'b0, 1'b1, 1'b1, 32'hDEADBEEF);
    wait_done("t4");
    bus.i_req_a = 0;
    check("t4_tmo_cycles", 64'(t_done - t_c0_fall), 64'(TMO));
    nack_mode = 1'b0;
    @(negedge clk);
    bus.i_req_b = 1; bus.i_wr_b = 1; bus.i_addr_b = 16'h0020; bus.i_wdata_b = 32'h12345678;
    push_exp(1'b1, 1'b0, 1'b0, 32'd0);
    wait_done("t4b");
    bus.i_req_b = 0;
    check("t4b_bytes", m_bytes, 56'hA0_0020_12345678);

    // 5: reset during tWR, request still pending -> re-granted from IDLE
    @(negedge clk);
    bus.i_req_a = 1; bus.i_wr_a = 1; bus.i_addr_a = 16'h0030; bus.i_wdata_a = 32'h0BADF00D;
    push_exp(1'b0, 1'b0, 1'b0, 32'd0);
    wait_c7_fall("t5");
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("t5_rst");
    exp_q.delete();
    rst = 1'b0;
    push_exp(1'b0, 1'b0, 1'b0, 32'd0);
    wait_done("t5");
    bus.i_req_a = 0;
    check("t5_bytes", m_bytes, 56'hA0_0030_0BADF00D);

    // 6: request raised during tWR waits for done of the write
    @(negedge clk);
    bus.i_req_a = 1; bus.i_wr_a = 1; bus.i_addr_a = 16'h0040; bus.i_wdata_a = 32'hCAFEF00D;
    push_exp(1'b0, 1'b0, 1'b0, 32'd0);
    wait_c7_fall("t6");
    bus.i_req_b = 1; bus.i_wr_b = 0; bus.i_addr_b = 16'h0010;
    push_exp(1'b1, 1'b0, 1'b1, 32'hDEADBEEF);
    wait_done("t6a");
    bus.i_req_a = 0;
    check("t6_gnt_b_blocked", bus.o_gnt_b, 1'b0);
    check("t6_twr_cycles", 64'(t_done - t_c7_fall), 64'(TWR));
    en0 = t_done;
    wait_done("t6b");
    bus.i_req_b = 0;
    check("t6_b_after_a", 64'(t_gntb_rise > en0), 64'd1);
    check("end_overlap", 64'(overlap), 64'd0);
    check("end_sb_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
